vga_rect_ctrl: RTL

- Rectangle-layer controller for the VGA pixel path.
- A host loads rectangle descriptors (bounds, colour, enable) into shadow registers over a valid/ready write port.
- On request, the block copies the shadow set into the active set at the start of vertical blanking, one descriptor per cycle, so a visible frame never shows a half-updated set.
- Every cycle it priority-resolves the active set against the current pixel coordinate and drives registered 4-bit RED/GREEN/BLUE.

---
 rtl/vga_rect_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_rect_ctrl.sv
// vga_rect_ctrl: shadow/active rectangle overlay; shadow set is committed to
// the active set at a vblank rising edge so a visible frame never tears.
module vga_rect_ctrl #(
  parameter int NRECT = 4,
  parameter int CW = 4,
  localparam int IW = NRECT > 1 ? $clog2(NRECT) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          de,
  input  logic          vblank,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic [2:0]    wr_field,
  input  logic [3*CW-1:0] wr_data,
  input  logic          commit_req,
  output logic          commit_done,
  output logic          busy,
  output logic [CW-1:0] RED,
  output logic [CW-1:0] GREEN,
  output logic [CW-1:0] BLUE
);
  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
  typedef struct packed {
    logic en;
    logic [3*CW-1:0] col;
    logic [9:0] y1, y0, x1, x0;
  } desc_t;

  state_t state_q, state_d;
  desc_t shadow_q [NRECT];
  desc_t shadow_d [NRECT];
  desc_t active_q [NRECT];
  desc_t active_d [NRECT];
  logic [IW-1:0] cnt_q, cnt_d;
  logic vb_q, done_q, done_d;
  logic [3*CW-1:0] rgb_q, rgb_d, win;

  assign wr_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign commit_done = done_q;
  assign {RED, GREEN, BLUE} = rgb_q;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    win = '0;
    if (wr_valid && wr_ready && 32'(wr_idx) < NRECT)
      case (wr_field)
        3'd0: shadow_d[wr_idx].x0 = wr_data[9:0];
        3'd1: shadow_d[wr_idx].x1 = wr_data[9:0];
        3'd2: shadow_d[wr_idx].y0 = wr_data[9:0];
        3'd3: shadow_d[wr_idx].y1 = wr_data[9:0];
        3'd4: shadow_d[wr_idx].col = wr_data;
        3'd5: shadow_d[wr_idx].en = wr_data[0];
        default: ;
      endcase
    case (state_q)
      IDLE: state_d = commit_req ? PENDING : IDLE;
      PENDING: begin
        state_d = vblank && !vb_q ? COPY : PENDING;
        cnt_d = '0;
      end
      COPY: begin
        active_d[cnt_q] = shadow_q[cnt_q];
        cnt_d = cnt_q + 1'b1;
        done_d = cnt_q == IW'(NRECT - 1);
        state_d = done_d ? IDLE : COPY;
      end
      default: state_d = IDLE;
    endcase
    // descending scan so the lowest-index hit is the last one written
    for (int i = NRECT - 1; i >= 0; i--)
      if (active_q[i].en && x >= active_q[i].x0 && x < active_q[i].x1 &&
          y >= active_q[i].y0 && y < active_q[i].y1)
        win = active_q[i].col;
    rgb_d = de ? win : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      cnt_q <= '0;
      vb_q <= 1'b0;
      done_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q <= cnt_d;
      vb_q <= vblank;
      done_q <= done_d;
      rgb_q <= rgb_d;
    end
  end
endmodule
